// File: rtl/trace_pkg.sv
// Shared definitions for the writeback trace path: entry layout and packing helper.
package trace_pkg;

    localparam int unsigned TRACE_W = 70;
    localparam int unsigned PC_LSB  = 38;
    localparam int unsigned ENA_BIT = 37;
    localparam int unsigned REG_LSB = 32;
    localparam int unsigned VAL_LSB = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  dst;
        logic [31:0] value;
    } trace_entry_t;

    // Writes to x0 are architecturally invisible, so they are traced as non-writes.
    function automatic trace_entry_t pack_entry(
        input logic [31:0] pc,
        input logic        ena,
        input logic [4:0]  dst,
        input logic [31:0] value
    );
        trace_entry_t e;
        e.pc    = pc;
        e.ena   = ena & (dst != 5'd0);
        e.dst   = dst;
        e.value = value;
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; head entry is read combinationally from storage.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 70,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic [AW:0]      level,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata_c = mem[rd_ptr];
    assign full_c  = (level == LW'(DEPTH));
    assign empty_c = (level == '0);

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures retired-instruction writeback records into a FWFT FIFO and streams them to a sink,
// counting retires and drops so the CPU is never stalled.
module wb_trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wb_have_inst,
    input  logic [31:0]       wb_pc,
    input  logic              wb_ena,
    input  logic [4:0]        wb_reg,
    input  logic [31:0]       wb_value,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic              trace_ena,
    output logic [4:0]        trace_reg,
    output logic [31:0]       trace_value,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [31:0]       retire_cnt
);

    trace_entry_t wr_entry;
    trace_entry_t head;
    logic         push_c;
    logic         pop_c;
    logic         drop_c;
    logic         full_c;
    logic         empty_c;
    logic [TRACE_W-1:0] rdata_c;

    assign wr_entry = pack_entry(wb_pc, wb_ena, wb_reg, wb_value);

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign pop_c  = trace_valid & trace_ready & ~clr;
    assign push_c = wb_have_inst & (~full_c | pop_c) & ~clr;
    assign drop_c = wb_have_inst & full_c & ~pop_c & ~clr;

    sync_fifo_fwft #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .push    (push_c),
        .pop     (pop_c),
        .wdata   (TRACE_W'(wr_entry)),
        .rdata_c (rdata_c),
        .level   (level),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign head        = trace_entry_t'(rdata_c);
    assign trace_valid = ~empty_c;
    assign trace_pc    = head.pc;
    assign trace_ena   = head.ena;
    assign trace_reg   = head.dst;
    assign trace_value = head.value;

    // Statistics: clear wins over any retire in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            retire_cnt <= '0;
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            if (wb_have_inst) begin
                retire_cnt <= retire_cnt + 32'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: vector table for basic flow plus queue-model sequences.
module tb_wb_trace_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned DROP_W = 16;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              wb_have_inst;
    logic [31:0]       wb_pc;
    logic              wb_ena;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_value;
    logic              trace_valid;
    logic              trace_ready;
    logic [31:0]       trace_pc;
    logic              trace_ena;
    logic [4:0]        trace_reg;
    logic [31:0]       trace_value;
    logic [AW:0]       level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;
    logic [31:0]       retire_cnt;

    int total;
    int bad;

    wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wb_have_inst (wb_have_inst),
        .wb_pc        (wb_pc),
        .wb_ena       (wb_ena),
        .wb_reg       (wb_reg),
        .wb_value     (wb_value),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_ena    (trace_ena),
        .trace_reg    (trace_reg),
        .trace_value  (trace_value),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        have;
        logic [31:0] pc;
        logic        ena;
        logic [4:0]  rg;
        logic [31:0] val;
        logic        rdy;
        logic        exp_valid;
        logic [4:0]  exp_level;
        logic [31:0] exp_pc;
        logic        exp_ena;
        logic [4:0]  exp_reg;
        logic [31:0] exp_val;
        logic [31:0] exp_retire;
    } vec_t;

    vec_t vecs[8];

    // Reference model state
    logic [31:0] mq[$];
    int          m_ret;
    int          m_drop;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ret  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
    endtask

    // One cycle of traffic checked against the queue model.
    task automatic mcycle(input logic have, input logic [31:0] pc, input logic rdy);
        logic        stalled;
        logic [31:0] held_pc;
        logic [31:0] held_val;
        wb_have_inst = have;
        wb_pc        = pc;
        wb_ena       = 1'b1;
        wb_reg       = 5'd7;
        wb_value     = ~pc;
        trace_ready  = rdy;
        clr          = 1'b0;
        chk("valid", 32'(trace_valid), 32'(mq.size() != 0));
        stalled  = trace_valid && !rdy;
        held_pc  = trace_pc;
        held_val = trace_value;
        if (mq.size() != 0 && rdy) begin
            chk("head_pc", trace_pc, mq[0]);
            chk("head_val", trace_value, ~mq[0]);
            void'(mq.pop_front());
        end
        if (have) begin
            m_ret++;
            if (mq.size() < DEPTH) begin
                mq.push_back(pc);
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end
        end
        step();
        if (stalled) begin
            chk("stall_pc", trace_pc, held_pc);
            chk("stall_val", trace_value, held_val);
        end
        chk("m_level", 32'(level), 32'(mq.size()));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        chk("m_drop", 32'(drop_cnt), 32'(m_drop));
        chk("m_retire", retire_cnt, 32'(m_ret));
        wb_have_inst = 1'b0;
        trace_ready  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_clear();
        rst_n        = 1'b0;
        clr          = 1'b0;
        wb_have_inst = 1'b0;
        wb_pc        = '0;
        wb_ena       = 1'b0;
        wb_reg       = '0;
        wb_value     = '0;
        trace_ready  = 1'b0;

        //           have pc      ena rg  val       rdy  v  lvl pc      ena rg  val       retire
        vecs[0] = '{1'b1, 32'h0, 1'b1, 5'd1, 32'h11,   1'b0, 1'b1, 5'd1, 32'h0, 1'b1, 5'd1, 32'h11,   32'd1};
        vecs[1] = '{1'b1, 32'h4, 1'b1, 5'd2, 32'h22,   1'b0, 1'b1, 5'd2, 32'h0, 1'b1, 5'd1, 32'h11,   32'd2};
        vecs[2] = '{1'b1, 32'h8, 1'b1, 5'd3, 32'h33,   1'b0, 1'b1, 5'd3, 32'h0, 1'b1, 5'd1, 32'h11,   32'd3};
        vecs[3] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd2, 32'h4, 1'b1, 5'd2, 32'h22,   32'd3};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 5'd1, 32'h8, 1'b1, 5'd3, 32'h33,   32'd3};
        vecs[5] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,    32'd3};
        vecs[6] = '{1'b1, 32'hC, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1, 5'd1, 32'hC, 1'b0, 5'd0, 32'hDEAD, 32'd4};
        vecs[7] = '{1'b0, 32'h0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,    32'd4};

        repeat (2) step();
        chk("rst_valid", 32'(trace_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic in-order flow and x0 masking
        for (int i = 0; i < 8; i++) begin
            wb_have_inst = vecs[i].have;
            wb_pc        = vecs[i].pc;
            wb_ena       = vecs[i].ena;
            wb_reg       = vecs[i].rg;
            wb_value     = vecs[i].val;
            trace_ready  = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(trace_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            chk($sformatf("v%0d_retire", i), retire_cnt, vecs[i].exp_retire);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i), trace_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_ena", i), 32'(trace_ena), 32'(vecs[i].exp_ena));
                chk($sformatf("v%0d_reg", i), 32'(trace_reg), 32'(vecs[i].exp_reg));
                chk($sformatf("v%0d_val", i), trace_value, vecs[i].exp_val);
            end
        end
        wb_have_inst = 1'b0;
        trace_ready  = 1'b0;

        // Clear to align the model, then overflow by 4
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        chk("clr0_retire", retire_cnt, 32'd0);
        for (int i = 0; i < 20; i++) mcycle(1'b1, 32'h100 + 32'(4 * i), 1'b0);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd4);
        chk("ovf_retire", retire_cnt, 32'd20);

        // Full with push and pop together: accepted, no drop
        mcycle(1'b1, 32'h900, 1'b1);
        chk("fullpp_level", 32'(level), 32'd16);
        chk("fullpp_drop", 32'(drop_cnt), 32'd4);
        for (int i = 0; i < 17; i++) mcycle(1'b0, 32'h0, 1'b1);
        chk("drained_valid", 32'(trace_valid), 32'd0);

        // Toggling ready under continuous retires
        for (int i = 0; i < 24; i++) mcycle(1'b1, 32'h2000 + 32'(4 * i), 1'(i % 2));
        for (int i = 0; i < 14; i++) mcycle(1'b0, 32'h0, 1'b1);

        // clr beats a same-cycle retire while partially full and overflowed
        for (int i = 0; i < 17; i++) mcycle(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
        for (int i = 0; i < 11; i++) mcycle(1'b0, 32'h0, 1'b1);
        chk("pre_clr_level", 32'(level), 32'd5);
        chk("pre_clr_ovf", 32'(overflow), 32'd1);
        clr          = 1'b1;
        wb_have_inst = 1'b1;
        wb_pc        = 32'h4000;
        trace_ready  = 1'b1;
        step();
        clr          = 1'b0;
        wb_have_inst = 1'b0;
        trace_ready  = 1'b0;
        model_clear();
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_valid", 32'(trace_valid), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_retire", retire_cnt, 32'd0);

        // Asynchronous reset in the middle of a drain
        for (int i = 0; i < 3; i++) mcycle(1'b1, 32'h5000 + 32'(4 * i), 1'b0);
        mcycle(1'b0, 32'h0, 1'b1);
        trace_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_valid", 32'(trace_valid), 32'd0);
        chk("arst_retire", retire_cnt, 32'd0);
        trace_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Downstream consumer of the CPU writeback debug port (debug_wb_have_inst/pc/ena/reg/value) at the SoC top.
- Captures one trace entry per retired instruction into a synchronous first-word-fall-through (FWFT) FIFO.
- Drains entries over a valid/ready stream to a trace sink (UART formatter, testbench comparator).
- Keeps retire, overflow and drop statistics so a slow sink never stalls the CPU; drops are accounted for instead.

Parameters:
- DEPTH, 16, number of entries; power of two, ≥2.
- AW, 4, pointer width; equals log2(DEPTH).
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of FIFO contents and statistics.
- wb_have_inst  in  1  an instruction retires this cycle.
- wb_pc  in  32  PC of the retiring instruction.
- wb_ena  in  1  register-file write enable.
- wb_reg  in  5  destination register.
- wb_value  in  32  write-back data.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  sink accepts the head entry.
- trace_pc  out  32  head entry PC.
- trace_ena  out  1  head entry effective write enable.
- trace_reg  out  5  head entry destination register.
- trace_value  out  32  head entry write data.
- level  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one entry dropped.
- drop_cnt  out  DROP_W  number of dropped entries, saturating.
- retire_cnt  out  32  number of retired instructions, wrapping.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Read/write pointers = 0, level = 0.
  - overflow = 0, drop_cnt = 0, retire_cnt = 0.
  - trace_valid = 0.
  - Storage array is not reset; trace_* data outputs are don't-care while trace_valid=0.
- Entry format (70 bits): {pc[31:0], ena_eff, reg[4:0], value[31:0]}.
  - ena_eff = wb_ena & (wb_reg != 0): writes to x0 are recorded as non-writes.
  - value is stored unchanged.
- push = wb_have_inst & (!full | pop).
  - Write at wr_ptr on the rising edge; wr_ptr increments and wraps modulo DEPTH.
- pop = trace_valid & trace_ready.
  - rd_ptr increments and wraps modulo DEPTH.
- FWFT timing:
  - trace_valid = (level != 0).
  - trace_* = mem[rd_ptr], combinational from storage.
  - An entry pushed in cycle N is visible at the outputs in cycle N+1 (latency 1).
- Stream rules:
  - trace_* must remain stable while trace_valid=1 and trace_ready=0.
  - trace_ready while trace_valid=0 has no effect.
- Level update:
  - level += push − pop.
  - Simultaneous push and pop leave level unchanged, whether the FIFO is empty or full.
  - Full with push and pop in the same cycle: the incoming entry is accepted, nothing is dropped.
  - Empty with push: no same-cycle bypass; the entry appears next cycle.
- Drop (wb_have_inst & full & !pop):
  - Entry is discarded.
  - overflow is set and stays set until clr or reset.
  - drop_cnt increments, saturating at 2^DROP_W − 1.
- retire_cnt increments on every wb_have_inst, accepted or dropped, and wraps at 2^32.
- clr=1 (synchronous, highest priority over push and pop in the same cycle):
  - Pointers, level, overflow, drop_cnt and retire_cnt all go to 0.
  - The wb_have_inst of that cycle is not stored and not counted.
- The CPU is never back-pressured.
- No internal FSM beyond the pointer logic: the FIFO is either empty, partial or full, derived from level.

Decomposition:
- Shared package (trace_pkg): TRACE_W = 70 and the field offsets PC_LSB = 38, ENA_BIT = 37, REG_LSB = 32, VAL_LSB = 0.
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH): storage, pointers, level, full/empty.
- Wrapper logic: entry packing, ena_eff masking, and the counter/flag logic.

Test Plan:
- Reset, then 3 retires (pc 0x0, 0x4, 0x8; reg 1, 2, 3; values 0x11, 0x22, 0x33) with trace_ready=0 → level=3, trace_valid=1, head pc=0x0. Then ready=1 for 3 cycles → entries drain in order, valid drops, retire_cnt=3.
- Retire with wb_ena=1, wb_reg=0, value 0xDEAD → stored trace_ena=0, trace_value=0xDEAD.
- ready=0, 20 back-to-back retires with DEPTH=16 → level=16, overflow=1, drop_cnt=4, retire_cnt=20. Drain → the first 16 PCs come out in order.
- FIFO full, retire and ready=1 in the same cycle → level stays 16, drop_cnt unchanged, new entry sits at the tail.
- ready toggling 1/0 every cycle under continuous retires → no entry lost, duplicated or reordered; trace_* stable while stalled.
- Assert clr together with a retire while level=5 and overflow=1 → next cycle level=0, overflow=0, drop_cnt=0, retire_cnt=0. Assert rst_n low mid-drain → outputs reset immediately, without waiting for a clock edge.
